// File: rtl/ram_bist.sv
// March-style built-in self-test initiator for a single-port synchronous RAM.
// Runs w(BG) up, r(BG)w(~BG) up, r(~BG)w(BG) down, r(BG) up, and stops on the
// first mismatching read, recording where it happened and what was seen.
module ram_bist #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND = 8'h55
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_datain,
    input  logic [DATA_WIDTH-1:0] ram_dataout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_element,
    output logic [ADDR_WIDTH-1:0] fail_address,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual
);

    typedef enum logic [3:0] {
        IDLE, E0_W, E1_R, E1_W, E2_R, E2_W, E3_R, E3_C, DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    pass_q, pass_d;
    logic [1:0]              failElement_q, failElement_d;
    logic [ADDR_WIDTH-1:0]   failAddress_q, failAddress_d;
    logic [DATA_WIDTH-1:0]   failExpected_q, failExpected_d;
    logic [DATA_WIDTH-1:0]   failActual_q, failActual_d;
    logic                    enD;
    logic [DATA_WIDTH-1:0]   dataD;
    logic                    cmpEn;
    logic [DATA_WIDTH-1:0]   cmpExpected;
    logic [1:0]              cmpElement;

    // State, address counter and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            pass_q         <= 1'b0;
            failElement_q  <= '0;
            failAddress_q  <= '0;
            failExpected_q <= '0;
            failActual_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            pass_q         <= pass_d;
            failElement_q  <= failElement_d;
            failAddress_q  <= failAddress_d;
            failExpected_q <= failExpected_d;
            failActual_q   <= failActual_d;
        end
    end

    // March sequencing; a compare mismatch overrides the element's write and ends the run
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        pass_d         = pass_q;
        failElement_d  = failElement_q;
        failAddress_d  = failAddress_q;
        failExpected_d = failExpected_q;
        failActual_d   = failActual_q;
        enD            = 1'b0;
        dataD          = '0;
        cmpEn          = 1'b0;
        cmpExpected    = '0;
        cmpElement     = 2'd0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d        = E0_W;
                    addr_d         = '0;
                    pass_d         = 1'b0;
                    failElement_d  = '0;
                    failAddress_d  = '0;
                    failExpected_d = '0;
                    failActual_d   = '0;
                end
            end
            E0_W: begin
                enD   = 1'b1;
                dataD = BACKGROUND;
                if (addr_q == LAST_ADDR) begin
                    state_d = E1_R;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ONE_ADDR;
                end
            end
            E1_R: state_d = E1_W;
            E1_W: begin
                cmpEn       = 1'b1;
                cmpExpected = BACKGROUND;
                cmpElement  = 2'd1;
                enD         = 1'b1;
                dataD       = ~BACKGROUND;
                if (addr_q == LAST_ADDR) begin
                    state_d = E2_R;
                end else begin
                    state_d = E1_R;
                    addr_d  = addr_q + ONE_ADDR;
                end
            end
            E2_R: state_d = E2_W;
            E2_W: begin
                cmpEn       = 1'b1;
                cmpExpected = ~BACKGROUND;
                cmpElement  = 2'd2;
                enD         = 1'b1;
                dataD       = BACKGROUND;
                if (addr_q == '0) begin
                    state_d = E3_R;
                end else begin
                    state_d = E2_R;
                    addr_d  = addr_q - ONE_ADDR;
                end
            end
            E3_R: state_d = E3_C;
            E3_C: begin
                cmpEn       = 1'b1;
                cmpExpected = BACKGROUND;
                cmpElement  = 2'd3;
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                    addr_d  = '0;
                    pass_d  = 1'b1;
                end else begin
                    state_d = E3_R;
                    addr_d  = addr_q + ONE_ADDR;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase

        if (cmpEn && (ram_dataout != cmpExpected)) begin
            state_d        = DONE;
            addr_d         = '0;
            pass_d         = 1'b0;
            enD            = 1'b0;
            dataD          = '0;
            failElement_d  = cmpElement;
            failAddress_d  = addr_q;
            failExpected_d = cmpExpected;
            failActual_d   = ram_dataout;
        end
    end

    // RAM port is gated by reset so nothing is written while reset is asserted
    always_comb begin
        ram_en      = enD & ~rst;
        ram_datain  = rst ? '0 : dataD;
        ram_address = addr_q;
    end

    // Status outputs derived from the registered state
    always_comb begin
        busy          = (state_q != IDLE) && (state_q != DONE);
        done          = (state_q == DONE);
        pass          = pass_q;
        fail_element  = failElement_q;
        fail_address  = failAddress_q;
        fail_expected = failExpected_q;
        fail_actual   = failActual_q;
    end

endmodule
